// File: rtl/crc8_pkg.sv
// rtl/crc8_pkg.sv - shared states and CRC-8 constants for the engine arbiter
`timescale 1ns/1ps
package crc8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT,
        RESULT,
        CLEAR,
        CLRW
    } state_t;

    localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;
    localparam logic [7:0] CRC8_INIT      = 8'h00;
    localparam int         CRC8_ENG_LAT   = 8;

    // One LSB-first step of the reflected CRC-8, as the engine does per bit.
    function automatic logic [7:0] crc8_bit_step(input logic [7:0] crc);
        return crc[0] ? ((crc >> 1) ^ CRC8_POLY_REFL) : (crc >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
`timescale 1ns/1ps
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] k;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = IDX_W'((int'(ptr) + i) % N_REQ);
            if (req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/crc8_arb_ctrl.sv
// rtl/crc8_arb_ctrl.sv - round-robin sequencer sharing one bit-serial CRC-8 engine
`timescale 1ns/1ps
module crc8_arb_ctrl
    import crc8_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ENG_LAT = CRC8_ENG_LAT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ*8-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     res_valid_o,
    output logic [7:0]           res_crc_o,
    input  logic [N_REQ-1:0]     res_ready_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic [7:0]           eng_din_o,
    output logic                 eng_valid_o,
    output logic                 eng_rd_o,
    input  logic [7:0]           eng_crc_i
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ENG_LAT + 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             cap_q, cap_d;
    logic [7:0]       crc_q, crc_d;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [7:0]       data_arr [N_REQ];

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid_i),
        .ptr   (rr_q),
        .found (arb_found),
        .idx   (arb_idx)
    );

    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            data_arr[r] = req_data_i[8*r +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            cap_q   <= 1'b0;
            crc_q   <= CRC8_INIT;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            cap_q   <= cap_d;
            crc_q   <= crc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        cap_d       = cap_q;
        crc_d       = crc_q;
        req_ready_o = '0;
        res_valid_o = '0;
        res_crc_o   = crc_q;
        eng_din_o   = '0;
        eng_valid_o = 1'b0;
        eng_rd_o    = 1'b0;
        busy_o      = (state_q != IDLE);
        grant_o     = '0;
        if (state_q != IDLE) begin
            grant_o[g_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    g_d     = arb_idx;
                    state_d = FEED;
                end
            end
            FEED: begin
                if (req_valid_i[g_q]) begin
                    eng_din_o        = data_arr[g_q];
                    eng_valid_o      = 1'b1;
                    req_ready_o[g_q] = 1'b1;
                    cnt_d            = CNT_W'(ENG_LAT - 1);
                    last_d           = req_last_i[g_q];
                    cap_d            = 1'b0;
                    state_d          = WAIT;
                end
            end
            WAIT: begin
                // After the last byte, one extra cycle lets the engine's
                // updated register become visible before it is captured.
                if (cap_q) begin
                    crc_d   = eng_crc_i;
                    cap_d   = 1'b0;
                    state_d = RESULT;
                end else if (cnt_q == '0) begin
                    if (last_q) begin
                        cap_d = 1'b1;
                    end else begin
                        state_d = FEED;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESULT: begin
                res_valid_o[g_q] = 1'b1;
                if (res_ready_i[g_q]) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                eng_rd_o = 1'b1;
                state_d  = CLRW;
                if (g_q == IDX_W'(N_REQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = g_q + 1'b1;
                end
            end
            CLRW: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_crc8_arb_ctrl.sv
// tb/tb_crc8_arb_ctrl.sv - directed bench for crc8_arb_ctrl with a bit-serial engine model
`timescale 1ns/1ps
module tb_crc8_arb_ctrl;

    localparam int N_REQ   = 2;
    localparam int ENG_LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_last, req_ready, res_valid, res_ready, grant;
    logic [15:0] req_data;
    logic [7:0]  res_crc, eng_din, eng_crc;
    logic        busy, eng_valid, eng_rd;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    logic [7:0] pkt [16];

    crc8_arb_ctrl #(.N_REQ(N_REQ), .ENG_LAT(ENG_LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .res_valid_o (res_valid),
        .res_crc_o   (res_crc),
        .res_ready_i (res_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .eng_din_o   (eng_din),
        .eng_valid_o (eng_valid),
        .eng_rd_o    (eng_rd),
        .eng_crc_i   (eng_crc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine: accept, ENG_LAT busy cycles shifting one bit each, then idle.
    logic [7:0] e_crc;
    int         e_cnt = 0;
    logic       e_rdb = 1'b0;
    logic       proto_err = 1'b0;

    function automatic logic [7:0] bstep(input logic [7:0] c);
        return c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            e_crc <= 8'h00;
            e_cnt <= 0;
            e_rdb <= 1'b0;
        end else begin
            if (eng_valid && eng_rd) proto_err <= 1'b1;
            if ((e_cnt != 0 || e_rdb) && (eng_valid || eng_rd)) proto_err <= 1'b1;
            if (e_rdb) begin
                e_rdb <= 1'b0;
            end else if (e_cnt != 0) begin
                if (e_cnt > 1) e_crc <= bstep(e_crc);
                e_cnt <= e_cnt - 1;
            end else if (eng_valid) begin
                e_crc <= bstep(e_crc ^ eng_din);
                e_cnt <= ENG_LAT;
            end else if (eng_rd) begin
                e_crc <= 8'h00;
                e_rdb <= 1'b1;
            end
        end
    end
    assign eng_crc = e_crc;

    function automatic logic [7:0] crc_ref(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ pkt[i];
            for (int b = 0; b < 8; b++) c = bstep(c);
        end
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; res_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_packet(input int r, input int n, input int stall_at, input int stall_len,
                               output logic [7:0] crc, output int first_cyc, output int res_cyc,
                               output int bad_gap, output int bad_din, output int stall_pulses,
                               output int stall_gap, output bit timeout);
        int k, prev, stall_left;
        bit ev, got, skip_gap;
        logic [7:0] din;
        k = 0; prev = -1; stall_left = 0; got = 0; skip_gap = 0;
        crc = 8'h00; first_cyc = -1; res_cyc = -1; bad_gap = 0; bad_din = 0;
        stall_pulses = 0; stall_gap = -1;
        @(posedge clk); #1;
        req_data[8*r +: 8] = pkt[0];
        req_last[r] = (n == 1);
        req_valid[r] = 1'b1;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge clk);
            ev = eng_valid; din = eng_din;
            if (res_valid != 0) begin
                got = 1; crc = res_crc; res_cyc = cyc;
            end else begin
                if (stall_left > 0 && ev) stall_pulses++;
                if (ev) begin
                    if (din !== pkt[k]) bad_din++;
                    if (prev >= 0) begin
                        if (skip_gap) stall_gap = cyc - prev;
                        else if (cyc - prev != ENG_LAT + 1) bad_gap++;
                    end
                    if (k == 0) first_cyc = cyc;
                    skip_gap = 0; prev = cyc;
                end
                @(posedge clk); #1;
                if (ev) begin
                    k++;
                    if (k < n) begin
                        req_data[8*r +: 8] = pkt[k];
                        req_last[r] = (k == n - 1);
                        if (k == stall_at && stall_len > 0) begin
                            req_valid[r] = 1'b0; stall_left = stall_len; skip_gap = 1;
                        end
                    end else begin
                        req_valid[r] = 1'b0; req_last[r] = 1'b0;
                    end
                end else if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) req_valid[r] = 1'b1;
                end
            end
        end
        timeout = !got;
    endtask

    task automatic ack_result(input int r, output int rd_pulses, output int ev_pulses, output int idle_iter);
        rd_pulses = 0; ev_pulses = 0; idle_iter = -1;
        @(posedge clk); #1 res_ready[r] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (eng_rd) rd_pulses++;
            if (eng_valid) ev_pulses++;
            if (!busy) begin
                idle_iter = i;
                break;
            end
            @(posedge clk); #1 res_ready[r] = 1'b0;
        end
        res_ready[r] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; res_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_grant_busy: got %b/%b, want 00/0", grant, busy);
        end
        vectors++;
        if (eng_valid !== 1'b0 || eng_rd !== 1'b0 || eng_din !== 8'h00) begin
            miscompares++; $display("FAIL reset_engine_if: got v=%b rd=%b din=%h, want 0/0/00", eng_valid, eng_rd, eng_din);
        end
        vectors++;
        if (res_valid !== 2'b00 || req_ready !== 2'b00 || res_crc !== 8'h00) begin
            miscompares++; $display("FAIL reset_result_if: got rv=%b rdy=%b crc=%h, want 00/00/00", res_valid, req_ready, res_crc);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL idle_without_request: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] crc; int fc, rc, bg, bd, sp, sg, rd, ev, ii; bit to;
        pkt[0] = 8'h01;
        send_packet(0, 1, -1, 0, crc, fc, rc, bg, bd, sp, sg, to);
        vectors++;
        if (to || crc !== 8'h5E) begin
            miscompares++; $display("FAIL single_crc: got %h (timeout=%0d), want 5e", crc, to);
        end
        vectors++;
        if (rc - fc != 10) begin
            miscompares++; $display("FAIL single_latency: got %0d cycles, want 10", rc - fc);
        end
        vectors++;
        if (res_valid !== 2'b01 || grant !== 2'b01) begin
            miscompares++; $display("FAIL single_owner: got rv=%b grant=%b, want 01/01", res_valid, grant);
        end
        ack_result(0, rd, ev, ii);
        vectors++;
        if (rd != 1 || ev != 0 || ii != 3) begin
            miscompares++; $display("FAIL single_clear: got rd=%0d ev=%0d idle_at=%0d, want 1/0/3", rd, ev, ii);
        end
    endtask

    task automatic test_stream();
        logic [7:0] crc; int fc, rc, bg, bd, sp, sg, rd, ev, ii; bit to;
        for (int i = 0; i < 9; i++) pkt[i] = 8'h31 + 8'(i);
        send_packet(1, 9, -1, 0, crc, fc, rc, bg, bd, sp, sg, to);
        vectors++;
        if (to || crc !== 8'hA1) begin
            miscompares++; $display("FAIL stream_crc: got %h (timeout=%0d), want a1", crc, to);
        end
        vectors++;
        if (bg != 0 || bd != 0) begin
            miscompares++; $display("FAIL stream_pacing: got bad_gaps=%0d bad_bytes=%0d, want 0/0", bg, bd);
        end
        vectors++;
        if (res_valid !== 2'b10) begin
            miscompares++; $display("FAIL stream_owner: got rv=%b, want 10", res_valid);
        end
        ack_result(1, rd, ev, ii);
        vectors++;
        if (rd != 1 || ii != 3) begin
            miscompares++; $display("FAIL stream_clear: got rd=%0d idle_at=%0d, want 1/3", rd, ii);
        end
    endtask

    task automatic test_hold_result();
        logic [7:0] crc; int fc, rc, bg, bd, sp, sg, rd, ev, ii, bad; bit to;
        pkt[0] = 8'h01;
        req_data = {8'h02, 8'h01}; req_last = 2'b11; req_valid = 2'b11;
        send_packet(0, 1, -1, 0, crc, fc, rc, bg, bd, sp, sg, to);
        vectors++;
        if (to || crc !== 8'h5E || bd != 0) begin
            miscompares++; $display("FAIL hold_first_grant: got crc=%h bad_bytes=%0d, want 5e/0", crc, bd);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (res_valid !== 2'b01 || res_crc !== 8'h5E || grant !== 2'b01 ||
                eng_valid !== 1'b0 || eng_rd !== 1'b0 || req_ready !== 2'b00) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL hold_stable: got %0d unstable cycles, want 0", bad);
        end
        req_valid = 2'b00;
        ack_result(0, rd, ev, ii);
        vectors++;
        if (rd != 1 || ii != 3) begin
            miscompares++; $display("FAIL hold_clear: got rd=%0d idle_at=%0d, want 1/3", rd, ii);
        end
    endtask

    task automatic test_stall();
        logic [7:0] crc, want; int fc, rc, bg, bd, sp, sg, rd, ev, ii; bit to;
        pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
        want = crc_ref(3);
        send_packet(0, 3, 2, ENG_LAT + 7, crc, fc, rc, bg, bd, sp, sg, to);
        vectors++;
        if (to || crc !== want) begin
            miscompares++; $display("FAIL stall_crc: got %h (timeout=%0d), want %h", crc, to, want);
        end
        vectors++;
        if (sp != 0) begin
            miscompares++; $display("FAIL stall_no_pulse: got %0d pulses, want 0", sp);
        end
        vectors++;
        if (sg != ENG_LAT + 1 + 7 || bg != 0) begin
            miscompares++; $display("FAIL stall_gap: got %0d (bad_gaps=%0d), want %0d/0", sg, bg, ENG_LAT + 8);
        end
        ack_result(0, rd, ev, ii);
        vectors++;
        if (rd != 1 || ii != 3) begin
            miscompares++; $display("FAIL stall_clear: got rd=%0d idle_at=%0d, want 1/3", rd, ii);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [4];
        logic [1:0] want_seq [4];
        int rds [4];
        int n, rdc, overlap, badcrc;
        bit done;
        logic [1:0] g, prev_g;
        want_seq[0] = 2'b01; want_seq[1] = 2'b10; want_seq[2] = 2'b01; want_seq[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin seq[i] = 2'b00; rds[i] = -1; end
        do_reset();
        req_data = {8'h02, 8'h01}; req_last = 2'b11; res_ready = 2'b11; req_valid = 2'b11;
        n = 0; rdc = 0; overlap = 0; badcrc = 0; done = 0; prev_g = 2'b00;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            g = grant;
            if ((g & (g - 2'd1)) != 2'b00) overlap++;
            if (eng_rd) rdc++;
            if (res_valid != 2'b00 && (res_valid !== g || res_crc !== (g == 2'b01 ? 8'h5E : 8'hBC))) badcrc++;
            if (prev_g == 2'b00 && g != 2'b00) begin
                if (n < 4) seq[n] = g;
                if (n > 0 && n <= 4) rds[n-1] = rdc;
                rdc = 0;
                n++;
            end
            if (n == 4 && !busy && prev_g != 2'b00) begin
                rds[3] = rdc; req_valid = 2'b00; done = 1;
            end
            prev_g = g;
        end
        res_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (seq[i] !== want_seq[i] || rds[i] != 1) begin
                miscompares++; $display("FAIL rr_grant_%0d: got grant=%b rd_pulses=%0d, want %b/1", i, seq[i], rds[i], want_seq[i]);
            end
        end
        vectors++;
        if (overlap != 0 || badcrc != 0 || !done) begin
            miscompares++; $display("FAIL rr_integrity: got overlap=%0d bad_results=%0d done=%0d, want 0/0/1", overlap, badcrc, done);
        end
    endtask

    task automatic test_reset_midpacket();
        logic [7:0] crc; int fc, rc, bg, bd, sp, sg, rd, ev, ii, pulses; bit to;
        @(posedge clk); #1;
        req_data[15:8] = 8'h11; req_last[1] = 1'b0; req_valid[1] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 100 && pulses < 3; c++) begin
            @(negedge clk);
            if (eng_valid) pulses++;
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++; $display("FAIL midpkt_bytes: got %0d bytes, want 3", pulses);
        end
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 2'b00; req_data = '0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (grant !== 2'b00 || busy !== 1'b0 || eng_valid !== 1'b0 || eng_rd !== 1'b0 ||
            res_valid !== 2'b00 || req_ready !== 2'b00 || res_crc !== 8'h00 || eng_din !== 8'h00) begin
            miscompares++; $display("FAIL midpkt_reset_outputs: got grant=%b busy=%b v=%b rd=%b rv=%b crc=%h, want all 0",
                                    grant, busy, eng_valid, eng_rd, res_valid, res_crc);
        end
        @(posedge clk); #1 rst = 1'b0;
        pkt[0] = 8'h01;
        send_packet(0, 1, -1, 0, crc, fc, rc, bg, bd, sp, sg, to);
        vectors++;
        if (to || crc !== 8'h5E || res_valid !== 2'b01) begin
            miscompares++; $display("FAIL midpkt_recover: got crc=%h rv=%b (timeout=%0d), want 5e/01", crc, res_valid, to);
        end
        ack_result(0, rd, ev, ii);
        vectors++;
        if (rd != 1 || ii != 3) begin
            miscompares++; $display("FAIL midpkt_clear: got rd=%0d idle_at=%0d, want 1/3", rd, ii);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_hold_result();
        test_stall();
        test_round_robin();
        test_reset_midpacket();
        vectors++;
        if (proto_err !== 1'b0) begin
            miscompares++; $display("FAIL engine_protocol: got violation=%b, want 0", proto_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
